// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-pass controller around a 4-bit barrel shifter.
// A command's total amount is split into passes of at most 3 bit positions.
// Each pass goes through one barrel_shifter and its result is registered.
// Optional build macro ROT_MOD_EN: rotate amounts are reduced mod 4 on accept.
// This shortens rotate latency without changing the result.

module barrel_shifter (
    input  logic       select,      // 0 = shift (zero fill), 1 = rotate
    input  logic       direction,   // 0 = right, 1 = left
    input  logic [1:0] shift_value,
    input  logic [3:0] data,
    output logic [3:0] result
);
    logic [7:0] dbl;

    assign dbl = {data, data};

    // Combinational shift/rotate by 0..3 positions
    always_comb begin
        result = data;
        case ({select, direction})
            2'b00:   result = data >> shift_value;
            2'b01:   result = data << shift_value;
            2'b10:   result = 4'(dbl >> shift_value);
            2'b11:   result = 4'((dbl << shift_value) >> 4);
            default: result = data;
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int AMT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_select,
    input  logic                 in_direction,
    input  logic [AMT_WIDTH-1:0] in_amount,
    input  logic [3:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_data,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [3:0]           work;
    logic [AMT_WIDTH-1:0] remaining;
    logic                 sel_q;
    logic                 dir_q;
    logic [1:0]           step;
    logic [AMT_WIDTH-1:0] rem_nxt;
    logic [AMT_WIDTH-1:0] load_amt;
    logic [3:0]           shift_out;
    logic                 accept;

`ifdef ROT_MOD_EN
    // A rotate by a multiple of 4 is the identity, so only amount mod 4 matters
    assign load_amt = in_select ? AMT_WIDTH'(in_amount[1:0]) : in_amount;
`else
    assign load_amt = in_amount;
`endif

    assign step      = (remaining >= AMT_WIDTH'(3)) ? 2'd3 : remaining[1:0];
    assign rem_nxt   = remaining - AMT_WIDTH'(step);
    assign accept    = (state == IDLE) && in_valid && !flush;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

    barrel_shifter u_shifter (
        .select      (sel_q),
        .direction   (dir_q),
        .shift_value (step),
        .data        (work),
        .result      (shift_out)
    );

    // Next-state logic; flush forces IDLE over both handshakes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (load_amt == '0) ? DONE : RUN;
            RUN:     if (rem_nxt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Work word, remaining count and latched mode: load on accept, one pass per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work      <= '0;
            remaining <= '0;
            sel_q     <= 1'b0;
            dir_q     <= 1'b0;
        end else if (accept) begin
            work      <= in_data;
            remaining <= load_amt;
            sel_q     <= in_select;
            dir_q     <= in_direction;
        end else if (state == RUN && !flush) begin
            work      <= shift_out;
            remaining <= rem_nxt;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed scenarios plus randomized commands
// checked against an arithmetic reference model of result and latency.
module tb_shift_sequencer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, in_select, in_direction;
    logic [AW-1:0] in_amount;
    logic [3:0]    in_data, out_data;
    logic          out_valid, out_ready, busy;

    int n_tests = 0;
    int n_fail  = 0;

    shift_sequencer #(.AMT_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_select(in_select), .in_direction(in_direction),
        .in_amount(in_amount), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected final word, from the meaning of shift/rotate by the full amount
    function automatic int model_result(input int sel, input int dir, input int amt, input int data);
        int r, d;
        if (sel == 1) begin
            r = amt % 4;
            d = data;
            if (r == 0) return d;
            if (dir == 1) return ((d * (1 << r)) | (d / (1 << (4 - r)))) & 15;
            return ((d / (1 << r)) | (d * (1 << (4 - r)))) & 15;
        end
        if (amt >= 4) return 0;
        if (dir == 1) return (data * (1 << amt)) & 15;
        return data / (1 << amt);
    endfunction

    // Expected cycle in which out_valid rises (accept edge ends cycle 0)
    function automatic int model_latency(input int sel, input int amt);
        int a;
        a = amt;
`ifdef ROT_MOD_EN
        if (sel == 1) a = amt % 4;
`endif
        return (a + 2) / 3 + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, track it to the result, hold it for `hold` cycles, then drain
    task automatic run_cmd(input int sel, input int dir, input int amt, input int data, input int hold);
        int c, exp_d, exp_l;
        exp_d = model_result(sel, dir, amt, data);
        exp_l = model_latency(sel, amt);
        check("pre_in_ready", in_ready, 1);
        in_valid = 1'b1; in_select = sel[0]; in_direction = dir[0];
        in_amount = AW'(amt); in_data = data[3:0];
        tick();
        in_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) check("run_hs", {busy, in_ready}, 2);
            tick();
            c++;
        end
        check("latency", c, exp_l);
        check("out_data", out_data, exp_d);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp_d);
            check("hold_ready_busy", {in_ready, busy}, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain", {out_valid, in_ready, busy}, 2);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_select = 1'b0;
        in_direction = 1'b0; in_amount = '0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_state", {in_ready, out_valid, busy, out_data}, 7'b1000000);
        rst_n = 1'b1;
        tick();

        // Directed scenarios
        run_cmd(1, 1, 5, 4'b0001, 0);   // -> 0010
        run_cmd(0, 0, 2, 4'b1000, 0);   // -> 0010
        run_cmd(0, 1, 7, 4'b0011, 1);   // -> 0000
        run_cmd(1, 0, 6, 4'b1001, 0);   // -> 0110
        run_cmd(0, 0, 0, 4'b1010, 5);   // amount 0, held
        run_cmd(1, 1, 4, 4'b0110, 0);
        run_cmd(0, 0, 15, 4'b1111, 0);

        // Flush during RUN
        in_valid = 1'b1; in_select = 1'b0; in_direction = 1'b1; in_amount = 4'd15; in_data = 4'b0001;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {in_ready, busy, out_valid}, 4);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) check("flush_no_valid", out_valid, 0);
        end
        check("flush_quiet", {out_valid, busy}, 0);
        run_cmd(1, 1, 1, 4'b0001, 0);

        // Accept coinciding with flush is dropped
        in_valid = 1'b1; flush = 1'b1; in_amount = 4'd3;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_drop", {in_ready, busy}, 2);
        tick();
        check("flush_accept_drop2", {out_valid, busy}, 0);

        // Reset while result pending in DONE
        in_valid = 1'b1; in_select = 1'b0; in_amount = 4'd0; in_data = 4'b1010;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", {out_valid, out_data}, 5'b11010);
        rst_n = 1'b0;
        tick();
        check("rst_done", {in_ready, out_valid, busy, out_data}, 7'b1000000);

        // Reset with flush and in_valid simultaneously
        flush = 1'b1; in_valid = 1'b1; in_amount = 4'd5; in_data = 4'b1111;
        tick();
        check("rst_combo", {in_ready, out_valid, busy, out_data}, 7'b1000000);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_combo_noaccept", {busy, out_valid}, 0);

        // Randomized commands
        for (int t = 0; t < 60; t++) begin
            run_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-pass controller for the 4-bit barrel_shifter datapath (shift/rotate by 0-3 per pass). Accepts one shift/rotate command with a total amount up to 2^AMT_WIDTH-1 over a valid/ready handshake. Decomposes the amount into passes of at most 3 through one internal barrel_shifter instance and registers each pass. Returns the final word over a second valid/ready handshake. Sits between a command source (CPU-side register block or testbench driver) and the result consumer.

Parameters:
AMT_WIDTH, 4, width of the total shift amount; legal amounts are 0..2^AMT_WIDTH-1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
flush  input  1  synchronous abort; drops any in-flight command
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid & in_ready at a clk edge
in_select  input  1  0 = shift (zero fill), 1 = rotate
in_direction  input  1  0 = right, 1 = left
in_amount  input  AMT_WIDTH  total bit positions to move
in_data  input  4  operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result when out_valid & out_ready at a clk edge
out_data  output  4  result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; work register, remaining counter, and latched select/direction = 0. Outputs in_ready=1, out_valid=0, out_data=0, busy=0 from the first cycle after the reset edge. Reset overrides flush and both handshakes, and aborts any operation in progress.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On accept: latch in_data into work, in_select, in_direction, and in_amount into remaining.
  - If in_amount==0, next state is DONE; otherwise, next state is RUN.
- RUN: in_ready=0.
  - Each cycle: step = 3 if remaining>=3, else remaining[1:0].
  - The shifter is driven with work, the latched select/direction, and shift_value=step.
  - work <= shifter output; remaining <= remaining-step.
  - When remaining-step==0, next state is DONE.
- DONE: out_valid=1, out_data=work; both held stable while out_ready=0. On out_ready=1, next state is IDLE.
- Latency: with the accept edge ending cycle 0 and k=ceil(amount/3), state is RUN in cycles 1..k and out_valid rises in cycle k+1 (cycle 1 for amount 0).
- Throughput: one command in flight. in_ready=0 in RUN and DONE, including the DONE cycle in which out_ready is accepted. A new command can be accepted the cycle after return to IDLE.
- Shift amounts >=4 produce 0000 by successive passes; no shortcut is taken.
- flush=1 at an edge (rst_n=1): next state is IDLE and any pending result is discarded. out_valid never asserts for the aborted command. flush takes priority over in_valid and out_ready in the same cycle. An IDLE accept coinciding with flush is dropped.
- out_data = work in every state; it is meaningful only while out_valid=1.

Optional Feature:
ROT_MOD_EN
- Defined: on accept with in_select=1, remaining is loaded with in_amount mod 4, so a rotate needs at most 1 RUN cycle. Shift commands are unaffected.
- Undefined: rotates use the full in_amount and take ceil(amount/3) RUN cycles. The final out_data is identical in both builds; only latency differs.

Test Plan:
- Rotate left, in_data=0001, amount=5 → two passes (3, 2); out_data=0010, out_valid in cycle 3 (cycle 2 with ROT_MOD_EN).
- Shift right, in_data=1000, amount=2 → out_data=0010, out_valid in cycle 2. Shift left 0011 by 7 → 0000, out_valid in cycle 4.
- Rotate right, in_data=1001, amount=6 → out_data=0110. Without ROT_MOD_EN: out_valid in cycle 3. With ROT_MOD_EN: out_valid in cycle 2 (loaded amount 2).
- Amount 0, in_data=1010 → out_valid in cycle 1, out_data=1010. Hold out_ready=0 for 5 cycles → out_data stable, in_ready=0, busy=1; then out_ready=1 → IDLE next cycle.
- flush during RUN (shift left 0001 by 15) → IDLE next cycle, out_valid stays 0. A following command (rotate left 0001 by 1) returns 0010 in cycle 2.
- rst_n=0 asserted in DONE with out_valid=1 → after the edge out_valid=0, out_data=0000, in_ready=1, busy=0. rst_n=0 together with flush=1 and in_valid=1 → same reset values, command not accepted.
